// File: rtl/mem_line_buffer.sv
// Single-line (32-byte) read buffer with write-through between a word-wide core port and a line-wide memory port.
// Optional hit/miss read counters are enabled by defining MEM_LINE_BUFFER_PERF_EN.
module mem_line_buffer (
   input  logic         clk,
   input  logic         rst,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [3:0]   mem_byte_enable,
   input  logic [31:0]  mem_address,
   input  logic [31:0]  mem_wdata,
   output logic [31:0]  mem_rdata,
   output logic         mem_resp,
   input  logic         invalidate,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_address,
   output logic [255:0] pmem_wdata,
   output logic [31:0]  pmem_byte_enable,
   input  logic [255:0] pmem_rdata,
   input  logic         pmem_resp
`ifdef MEM_LINE_BUFFER_PERF_EN
   ,
   output logic [31:0]  hit_count,
   output logic [31:0]  miss_count
`endif
);

   localparam int unsigned LINE_W = 256;
   localparam int unsigned TAG_W  = 27;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned BYTES  = 4;

   typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

   state_t              state_q, state_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic                valid_q, valid_d;
   logic [WORD_W-1:0]   rdata_d;
   logic                resp_d, pread_d, pwrite_d;
   logic [31:0]         paddr_d;
   logic [LINE_W-1:0]   pwdata_d;
   logic [31:0]         pbe_d;

   logic [TAG_W-1:0]    addr_tag;
   logic [2:0]          offset;
   logic [7:0]          word_base;
   logic                hit;
   logic                addr_unused;

   assign addr_tag    = mem_address[31:5];
   assign offset      = mem_address[4:2];
   assign word_base   = {offset, 5'b0};
   assign hit         = valid_q && (tag_q == addr_tag);
   assign addr_unused = ^mem_address[1:0];

   // Next-state and next-register values; strobes are registered from these.
   always_comb begin
      state_d  = state_q;
      line_d   = line_q;
      tag_d    = tag_q;
      valid_d  = valid_q;
      rdata_d  = mem_rdata;
      resp_d   = 1'b0;
      pread_d  = pmem_read;
      pwrite_d = pmem_write;
      paddr_d  = pmem_address;
      pwdata_d = pmem_wdata;
      pbe_d    = pmem_byte_enable;

      case (state_q)
         IDLE: begin
            if (mem_write) begin
               state_d  = WRITE;
               pwrite_d = 1'b1;
               paddr_d  = {addr_tag, 5'b0};
               pwdata_d = {8{mem_wdata}};
               pbe_d    = 32'(mem_byte_enable) << {offset, 2'b00};
            end else if (mem_read) begin
               if (hit) begin
                  state_d = RESP;
                  resp_d  = 1'b1;
                  rdata_d = line_q[word_base +: WORD_W];
               end else begin
                  state_d = FILL;
                  pread_d = 1'b1;
                  paddr_d = {addr_tag, 5'b0};
               end
            end
         end
         FILL: begin
            if (pmem_resp) begin
               state_d = RESP;
               resp_d  = 1'b1;
               pread_d = 1'b0;
               line_d  = pmem_rdata;
               tag_d   = addr_tag;
               valid_d = 1'b1;
               rdata_d = pmem_rdata[word_base +: WORD_W];
            end
         end
         WRITE: begin
            if (pmem_resp) begin
               state_d  = RESP;
               resp_d   = 1'b1;
               pwrite_d = 1'b0;
               // Keep the buffered copy coherent with the written-through bytes.
               if (hit && !invalidate) begin
                  for (int i = 0; i < int'(BYTES); i++) begin
                     if (mem_byte_enable[2'(i)])
                        line_d[word_base + 8'(i * 8) +: 8] = mem_wdata[5'(i * 8) +: 8];
                  end
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (invalidate)
         valid_d = 1'b0;
   end

   // State, buffer and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= IDLE;
         line_q           <= '0;
         tag_q            <= '0;
         valid_q          <= 1'b0;
         mem_rdata        <= '0;
         mem_resp         <= 1'b0;
         pmem_read        <= 1'b0;
         pmem_write       <= 1'b0;
         pmem_address     <= '0;
         pmem_wdata       <= '0;
         pmem_byte_enable <= '0;
      end else begin
         state_q          <= state_d;
         line_q           <= line_d;
         tag_q            <= tag_d;
         valid_q          <= valid_d;
         mem_rdata        <= rdata_d;
         mem_resp         <= resp_d;
         pmem_read        <= pread_d;
         pmem_write       <= pwrite_d;
         pmem_address     <= paddr_d;
         pmem_wdata       <= pwdata_d;
         pmem_byte_enable <= pbe_d;
      end
   end

`ifdef MEM_LINE_BUFFER_PERF_EN
   // Saturating read counters, bumped on entry to RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (state_q == IDLE && state_d == RESP && hit_count != 32'hFFFF_FFFF)
            hit_count <= hit_count + 32'd1;
         if (state_q == FILL && state_d == RESP && miss_count != 32'hFFFF_FFFF)
            miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_line_buffer.sv
// Self-checking bench for mem_line_buffer: directed scenarios then randomized traffic against a
// memory-image reference model; checks counters too when MEM_LINE_BUFFER_PERF_EN is defined.
module tb_mem_line_buffer;

   logic         clk = 1'b0;
   logic         rst;
   logic         mem_read, mem_write;
   logic [3:0]   mem_byte_enable;
   logic [31:0]  mem_address, mem_wdata, mem_rdata;
   logic         mem_resp;
   logic         invalidate;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [31:0]  pmem_byte_enable;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;
`ifdef MEM_LINE_BUFFER_PERF_EN
   logic [31:0]  hit_count, miss_count;
`endif

   always #5 clk = ~clk;

   mem_line_buffer dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .invalidate(invalidate),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef MEM_LINE_BUFFER_PERF_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   int tests = 0;
   int fails = 0;

   // Reference: the physical memory image plus which line (if any) the buffer should be holding.
   logic [255:0] mem_img [bit [26:0]];
   bit           m_valid = 1'b0;
   bit [26:0]    m_tag   = '0;
   int           m_hits  = 0;
   int           m_misses = 0;

   function automatic logic [255:0] line_of(bit [26:0] t);
      logic [255:0] l;
      if (!mem_img.exists(t)) begin
         for (int i = 0; i < 8; i++) l = {l[223:0], 32'($urandom)};
         mem_img[t] = l;
      end
      return mem_img[t];
   endfunction

   function automatic logic [255:0] noise();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l = {l[223:0], 32'($urandom)};
      return l;
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_read(input logic [31:0] a, input bit inv, input int lat);
      bit [26:0]    t;
      bit           hit;
      logic [255:0] ln;
      logic [31:0]  exp;
      t   = a[31:5];
      ln  = line_of(t);
      exp = 32'(ln >> (32 * int'(a[4:2])));
      hit = m_valid && (m_tag == t);
      @(negedge clk);
      mem_read = 1'b1; mem_address = a;
      @(negedge clk);
      if (hit) begin
         check("rd_hit_resp", 256'(mem_resp), 256'(1'b1));
         check("rd_hit_no_pmem", 256'(pmem_read), 256'(1'b0));
         check("rd_hit_data", 256'(mem_rdata), 256'(exp));
         m_hits++;
      end else begin
         check("rd_miss_pread", 256'(pmem_read), 256'(1'b1));
         check("rd_miss_addr", 256'(pmem_address), 256'({t, 5'b0}));
         check("rd_miss_early_resp", 256'(mem_resp), 256'(1'b0));
         repeat (lat) @(negedge clk);
         if (lat > 0) begin
            check("rd_miss_pread_hold", 256'(pmem_read), 256'(1'b1));
            check("rd_miss_addr_hold", 256'(pmem_address), 256'({t, 5'b0}));
         end
         pmem_resp = 1'b1; pmem_rdata = ln; invalidate = inv;
         @(negedge clk);
         pmem_resp = 1'b0; pmem_rdata = noise(); invalidate = 1'b0;
         check("rd_miss_resp", 256'(mem_resp), 256'(1'b1));
         check("rd_miss_pread_drop", 256'(pmem_read), 256'(1'b0));
         check("rd_miss_data", 256'(mem_rdata), 256'(exp));
         m_misses++;
         m_valid = !inv;
         m_tag   = t;
      end
      mem_read = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                           input bit inv, input int lat);
      bit [26:0]    t;
      int           off;
      logic [255:0] ln, mask;
      logic [31:0]  exp_be;
      t      = a[31:5];
      off    = int'(a[4:2]);
      ln     = line_of(t);
      exp_be = '0;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            exp_be = exp_be | (32'd1 << (4 * off + i));
            mask   = 256'hFF << (8 * (4 * off + i));
            ln     = (ln & ~mask) | (256'(wd[8*i +: 8]) << (8 * (4 * off + i)));
         end
      end
      @(negedge clk);
      mem_write = 1'b1; mem_address = a; mem_byte_enable = be; mem_wdata = wd;
      @(negedge clk);
      check("wr_pwrite", 256'(pmem_write), 256'(1'b1));
      check("wr_addr", 256'(pmem_address), 256'({t, 5'b0}));
      check("wr_wdata", pmem_wdata, {8{wd}});
      check("wr_be", 256'(pmem_byte_enable), 256'(exp_be));
      repeat (lat) @(negedge clk);
      if (lat > 0) check("wr_be_hold", 256'(pmem_byte_enable), 256'(exp_be));
      pmem_resp = 1'b1; invalidate = inv;
      @(negedge clk);
      pmem_resp = 1'b0; invalidate = 1'b0;
      check("wr_resp", 256'(mem_resp), 256'(1'b1));
      check("wr_pwrite_drop", 256'(pmem_write), 256'(1'b0));
      mem_img[t] = ln;
      if (inv) m_valid = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic pulse_invalidate();
      @(negedge clk);
      invalidate = 1'b1;
      @(negedge clk);
      invalidate = 1'b0;
      m_valid = 1'b0;
   endtask

   initial begin
      logic [255:0] ln;
      logic [31:0]  old;
      logic [31:0]  a;
      int           op;

      rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = '0;
      mem_address = '0; mem_wdata = '0; invalidate = 1'b0;
      pmem_rdata = '0; pmem_resp = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mem_resp", 256'(mem_resp), 256'(1'b0));
      check("rst_pread", 256'(pmem_read), 256'(1'b0));
      check("rst_pwrite", 256'(pmem_write), 256'(1'b0));
      check("rst_rdata", 256'(mem_rdata), 256'(32'h0));
      check("rst_paddr", 256'(pmem_address), 256'(32'h0));
      check("rst_pwdata", pmem_wdata, 256'h0);
      check("rst_pbe", 256'(pmem_byte_enable), 256'(32'h0));
      rst = 1'b1;

      // Miss fill returning a known word.
      ln = line_of(27'h80);
      ln[63:32] = 32'hDEAD_BEEF;
      mem_img[27'h80] = ln;
      do_read(32'h0000_1004, 1'b0, 2);
      do_read(32'h0000_101C, 1'b0, 0);

      // Write hit merges two low bytes.
      old = 32'(mem_img[27'h80] >> 64);
      do_write(32'h0000_1008, 4'b0011, 32'h1234_5678, 1'b0, 1);
      check("tp_be_0300", 256'(pmem_byte_enable), 256'(32'h0000_0300));
      do_read(32'h0000_1008, 1'b0, 0);
      check("tp_merge", 256'(mem_rdata), 256'({old[31:16], 16'h5678}));

      // Write miss does not allocate.
      do_write(32'h0000_2000, 4'b1111, 32'hCAFE_F00D, 1'b0, 0);
      do_read(32'h0000_1000, 1'b0, 0);

      // Invalidate on the fill completion edge.
      do_read(32'h0000_3000, 1'b1, 1);
      do_read(32'h0000_3000, 1'b0, 0);

      // Asynchronous reset in the middle of a fill.
      @(negedge clk);
      mem_read = 1'b1; mem_address = 32'h0000_5004;
      @(negedge clk);
      check("rstmid_pread_before", 256'(pmem_read), 256'(1'b1));
      #2 rst = 1'b0;
      #1;
      check("rstmid_pread_drop", 256'(pmem_read), 256'(1'b0));
      check("rstmid_paddr", 256'(pmem_address), 256'(32'h0));
      mem_read = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      m_valid = 1'b0; m_hits = 0; m_misses = 0;

      // A stray pmem_resp in IDLE must be ignored.
      @(negedge clk);
      pmem_resp = 1'b1;
      @(negedge clk);
      pmem_resp = 1'b0;
      check("stray_resp_mem_resp", 256'(mem_resp), 256'(1'b0));
      check("stray_resp_pread", 256'(pmem_read), 256'(1'b0));

      do_read(32'h0000_3000, 1'b0, 0);
      do_read(32'h0000_3004, 1'b0, 0);
`ifdef MEM_LINE_BUFFER_PERF_EN
      @(negedge clk);
      check("perf_miss_1", 256'(miss_count), 256'(32'd1));
      check("perf_hit_1", 256'(hit_count), 256'(32'd1));
`endif

      // Randomized traffic over a few neighbouring lines.
      for (int n = 0; n < 300; n++) begin
         op = int'($urandom_range(0, 7));
         a  = 32'h0000_4000 + (32'($urandom_range(0, 3)) << 5) + (32'($urandom_range(0, 7)) << 2)
              + 32'($urandom_range(0, 3));
         if (op < 4)
            do_read(a, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)));
         else if (op < 7)
            do_write(a, 4'($urandom), 32'($urandom), ($urandom_range(0, 5) == 0),
                     int'($urandom_range(0, 3)));
         else
            pulse_invalidate();
      end

`ifdef MEM_LINE_BUFFER_PERF_EN
      @(negedge clk);
      check("perf_hits_final", 256'(hit_count), 256'(32'(m_hits)));
      check("perf_misses_final", 256'(miss_count), 256'(32'(m_misses)));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_line_buffer.md
# mem_line_buffer

- Single-line (256-bit) read buffer with write-through, placed between the multicycle RV32I core's word memory port and the 256-bit line-wide physical memory port.
- Read hits return in one cycle without touching physical memory.
- Read misses fetch the whole aligned 32-byte line.
- Writes always go through to physical memory and update the buffered line on a hit.
- The core sees the same request/response handshake as with a flat word memory.

## Interface
- Parameters: none. Line size fixed at 32 bytes, 8 words.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (`rst = 0` resets).
- `mem_read`  in  1  core word read request, held until `mem_resp`.
- `mem_write`  in  1  core word write request, held until `mem_resp`.
- `mem_byte_enable`  in  4  write byte lanes.
- `mem_address`  in  32  byte address; bits [1:0] ignored.
- `mem_wdata`  in  32  write data.
- `mem_rdata`  out  32  read data; valid only while `mem_resp` = 1.
- `mem_resp`  out  1  one-cycle completion pulse.
- `invalidate`  in  1  single-cycle pulse that clears the buffer valid bit.
- `pmem_read`  out  1  line read request, held until `pmem_resp`.
- `pmem_write`  out  1  line write request, held until `pmem_resp`.
- `pmem_address`  out  32  line-aligned address, bits [4:0] = 0.
- `pmem_wdata`  out  256  write data.
- `pmem_byte_enable`  out  32  write byte lanes.
- `pmem_rdata`  in  256  read line; valid when `pmem_resp` = 1.
- `pmem_resp`  in  1  one-cycle completion pulse.

## Operation
- Storage: `line[255:0]`, `tag[26:0]`, `valid`.
- Address split: tag = `mem_address[31:5]`, word offset = `mem_address[4:2]`.
- Hit: `valid` && stored tag == address tag.
- State machine: IDLE, FILL, WRITE, RESP.
- IDLE:
  - If `mem_write` → WRITE. Write has priority if both requests are high.
  - Else if `mem_read` && hit: latch `line` word at offset into the `mem_rdata` register → RESP.
  - Else if `mem_read` && miss → FILL.
- FILL:
  - `pmem_read` = 1, `pmem_address` = {tag, 5'b0}.
  - On `pmem_resp`: `line` ← `pmem_rdata`, `tag` ← address tag, `valid` ← 1, latch requested word → RESP.
- WRITE:
  - `pmem_write` = 1.
  - `pmem_wdata` = `mem_wdata` replicated to all 8 word slots.
  - `pmem_byte_enable` = `mem_byte_enable` << (4 × offset); all other lanes 0.
  - On `pmem_resp`: if hit, merge the enabled bytes into `line` → RESP.
  - Write miss: no allocate; line, tag and valid unchanged.
- RESP: `mem_resp` = 1 for exactly one cycle → IDLE. The core's still-high request in this cycle is ignored.
- `invalidate` in any state clears `valid` on the next edge.
  - If it coincides with the FILL completion edge, the fill data is still returned to the core, but `valid` ends at 0.
  - If it coincides with a WRITE completion hit, the merge is skipped and `valid` ends at 0.
- Core address and data are used combinationally from the held inputs. No request capture register is needed, because the core holds its inputs stable until `mem_resp`.

## Timing
- Reset values:
  - `mem_resp`, `pmem_read`, `pmem_write` = 0.
  - `mem_rdata`, `pmem_wdata`, `pmem_byte_enable`, `pmem_address` = 0.
  - state = IDLE, `valid` = 0, `line` and `tag` = 0.
- Reset asserted mid-FILL or mid-WRITE drops the pmem strobes immediately (asynchronous). A late `pmem_resp` arriving in IDLE is ignored.
- `pmem_*` and `mem_resp` are driven from registered state; there is no combinational path from inputs to strobes.
- Read hit: request sampled at edge N, `mem_resp` high in cycle N+1.
- Read miss / write: `mem_resp` high the cycle after the `pmem_resp` cycle.
- The next core request may be sampled in the cycle after RESP (back-to-back supported).
- `pmem_address`, `pmem_wdata` and `pmem_byte_enable` stay stable for the whole FILL/WRITE.

## Configuration
- `MEM_LINE_BUFFER_PERF_EN` defined:
  - Adds outputs `hit_count` (out, 32) and `miss_count` (out, 32).
  - Each counts completed core reads, incrementing on entry to RESP.
  - Both saturate at 0xFFFFFFFF and reset to 0.
  - Writes are not counted.
- Macro undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then read 0x0000_1004 → FILL with `pmem_address` 0x0000_1000. Memory returns a line with word1 = 0xDEADBEEF → `mem_rdata` = 0xDEADBEEF with `mem_resp` one cycle after `pmem_resp`.
- Next, read 0x0000_101C → no `pmem_read`; `mem_resp` on the 2nd cycle with `mem_rdata` = line word 7.
- Write 0x0000_1008, byte enable 4'b0011, data 0x1234_5678 → `pmem_byte_enable` 0x0000_0300. Then read 0x0000_1008 hits and returns the old upper half with low half 0x5678.
- Write 0x0000_2000 (miss), then read 0x0000_1000 → still a hit; tag unchanged.
- `invalidate` pulsed on the FILL completion edge → core still gets its data; the following read to the same line issues `pmem_read`.
- `rst` dropped while `pmem_read` = 1 → `pmem_read` = 0 with no clock edge. After release, a read of the previously buffered line misses. With `MEM_LINE_BUFFER_PERF_EN`: after 1 miss + 1 hit, `miss_count` = 1 and `hit_count` = 1.
